// File: rtl/row_buffer_ctrl_if.sv
// Row buffer controller bus: producer handshake, display timing, row memory
// port and status lines grouped in one bundle.
interface row_buffer_ctrl_if #(
    parameter int A = 9,
    parameter int S = 24
);
    logic         in_valid;
    logic [S-1:0] in_data;
    logic         in_ready;
    logic         line_start;
    logic         pix_req;
    logic [A-1:0] mem_address_write;
    logic [S-1:0] mem_data_write;
    logic         mem_wren;
    logic [A-1:0] mem_address_read;
    logic         mem_swap;
    logic         scan_active;
    logic         row_valid;
    logic         underrun;

    // Environment side: producer, display timing and row memory.
    modport master (
        output in_valid, in_data, line_start, pix_req,
        input  in_ready, mem_address_write, mem_data_write, mem_wren,
               mem_address_read, mem_swap, scan_active, row_valid, underrun
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data, line_start, pix_req,
        output in_ready, mem_address_write, mem_data_write, mem_wren,
               mem_address_read, mem_swap, scan_active, row_valid, underrun
    );
endinterface

// File: rtl/row_buffer_ctrl.sv
// Double-buffered row controller. The writer fills one half of the row
// memory from the producer while the reader walks the other half for the
// display. A line_start exchanges the halves only when the written row is
// complete; otherwise it flags an underrun and the old row is shown again.
module row_buffer_ctrl #(
    parameter int A = 9,
    parameter int S = 24,
    parameter int W = 320
) (
    input  logic              clock,
    input  logic              reset,
    row_buffer_ctrl_if.slave  bus
);
    typedef enum logic { WR_FILL = 1'b0, WR_DONE = 1'b1 } wr_state_t;
    typedef enum logic { RD_IDLE = 1'b0, RD_SCAN = 1'b1 } rd_state_t;

    localparam logic [A-1:0] LAST_PTR = A'(W - 1);
    localparam logic [A-1:0] ZERO_PTR = {A{1'b0}};
    localparam logic [A-1:0] ONE_PTR  = A'(1'b1);

    wr_state_t    wr_state_r, wr_state_s;
    rd_state_t    rd_state_r, rd_state_s;
    logic [A-1:0] wr_ptr_r, wr_ptr_s;
    logic [A-1:0] rd_ptr_r, rd_ptr_s;
    logic         row_valid_r, row_valid_s;
    logic         in_ready_s;
    logic         accept_s;
    logic         complete_s;
    logic         swap_s;
    logic         underrun_s;

    // Writer: handshake, row completion, swap/underrun decision and next pointer.
    always_comb begin
        wr_state_s  = wr_state_r;
        wr_ptr_s    = wr_ptr_r;
        row_valid_s = row_valid_r;
        in_ready_s  = (wr_state_r == WR_FILL) && !reset;
        accept_s    = bus.in_valid && in_ready_s;
        complete_s  = (wr_state_r == WR_DONE) || (accept_s && (wr_ptr_r == LAST_PTR));
        swap_s      = bus.line_start && complete_s && !reset;
        underrun_s  = bus.line_start && !complete_s && !reset;
        if (swap_s) begin
            wr_state_s  = WR_FILL;
            wr_ptr_s    = ZERO_PTR;
            row_valid_s = 1'b1;
        end else if (accept_s) begin
            if (wr_ptr_r == LAST_PTR) begin
                wr_state_s = WR_DONE;
            end else begin
                wr_ptr_s = wr_ptr_r + ONE_PTR;
            end
        end else begin
            wr_state_s = wr_state_r;
        end
    end

    // Reader: line_start restarts the scan, pix_req walks it to the last pixel.
    always_comb begin
        rd_state_s = rd_state_r;
        rd_ptr_s   = rd_ptr_r;
        if (bus.line_start) begin
            rd_state_s = RD_SCAN;
            rd_ptr_s   = ZERO_PTR;
        end else begin
            case (rd_state_r)
                RD_SCAN: begin
                    if (bus.pix_req) begin
                        if (rd_ptr_r == LAST_PTR) begin
                            rd_state_s = RD_IDLE;
                        end else begin
                            rd_ptr_s = rd_ptr_r + ONE_PTR;
                        end
                    end else begin
                        rd_state_s = RD_SCAN;
                    end
                end
                RD_IDLE: rd_state_s = RD_IDLE;
                default: rd_state_s = RD_IDLE;
            endcase
        end
    end

    // State and pointer registers; reset discards any partial row.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state_r  <= WR_FILL;
            wr_ptr_r    <= ZERO_PTR;
            rd_state_r  <= RD_IDLE;
            rd_ptr_r    <= ZERO_PTR;
            row_valid_r <= 1'b0;
        end else begin
            wr_state_r  <= wr_state_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_state_r  <= rd_state_s;
            rd_ptr_r    <= rd_ptr_s;
            row_valid_r <= row_valid_s;
        end
    end

    assign bus.in_ready          = in_ready_s;
    assign bus.mem_wren          = accept_s;
    assign bus.mem_address_write = wr_ptr_r;
    assign bus.mem_data_write    = bus.in_data;
    assign bus.mem_swap          = swap_s;
    assign bus.underrun          = underrun_s;
    assign bus.row_valid         = row_valid_r;
    assign bus.scan_active       = (rd_state_r == RD_SCAN);
    assign bus.mem_address_read  = rd_ptr_r;
endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Randomized bench for row_buffer_ctrl with W at the full 2^A range (A=2, W=4).
// The reference model tracks the number of pixels written into the pending
// row and the reader position as plain integers.
module tb_row_buffer_ctrl;
    localparam int A = 2;
    localparam int S = 24;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state
    int   m_cnt   = 0;   // pixels written into the pending row (W = complete)
    bit   m_valid = 1'b0;
    int   m_rd    = 0;
    bit   m_scan  = 1'b0;

    row_buffer_ctrl_if #(.A(A), .S(S)) bus_if ();

    row_buffer_ctrl #(.A(A), .S(S), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model,
    // then advance the model at the rising edge.
    task automatic step(input logic v, input logic [S-1:0] d, input logic ls,
                        input logic pr, input logic rs);
        bit acc;
        int after;
        @(negedge clock);
        bus_if.in_valid   = v;
        bus_if.in_data    = d;
        bus_if.line_start = ls;
        bus_if.pix_req    = pr;
        reset             = rs;
        if (rs) begin
            m_cnt = 0; m_valid = 1'b0; m_rd = 0; m_scan = 1'b0;
        end
        #1;
        acc   = !rs && v && (m_cnt < W);
        after = m_cnt + (acc ? 1 : 0);
        chk("in_ready", 32'(bus_if.in_ready), 32'(!rs && (m_cnt < W)));
        chk("mem_wren", 32'(bus_if.mem_wren), 32'(acc));
        if (acc) begin
            chk("wr_addr", 32'(bus_if.mem_address_write), 32'(m_cnt));
            chk("wr_data", 32'(bus_if.mem_data_write), 32'(d));
        end
        chk("mem_swap", 32'(bus_if.mem_swap), 32'(!rs && ls && (after == W)));
        chk("underrun", 32'(bus_if.underrun), 32'(!rs && ls && (after < W)));
        chk("row_valid", 32'(bus_if.row_valid), 32'(m_valid));
        chk("scan_active", 32'(bus_if.scan_active), 32'(m_scan));
        chk("rd_addr", 32'(bus_if.mem_address_read), 32'(m_rd));
        @(posedge clock);
        if (!rs) begin
            if (ls && (after == W)) begin
                m_cnt   = 0;
                m_valid = 1'b1;
            end else begin
                m_cnt = after;
            end
            if (ls) begin
                m_scan = 1'b1;
                m_rd   = 0;
            end else if (m_scan && pr) begin
                if (m_rd == W - 1) m_scan = 1'b0;
                else m_rd = m_rd + 1;
            end
        end
        #1;
    endtask

    initial begin
        bus_if.in_valid   = 1'b0;
        bus_if.in_data    = 24'd0;
        bus_if.line_start = 1'b0;
        bus_if.pix_req    = 1'b0;

        // Reset state, with a line_start and offered pixel that must be ignored
        step(1'b1, 24'd99, 1'b1, 1'b0, 1'b1);
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);

        // line_start right after reset release: underrun, no row
        step(1'b0, 24'd0, 1'b1, 1'b0, 1'b0);
        chk("r044_row_valid", 32'(bus_if.row_valid), 32'd0);
        chk("r044_scan", 32'(bus_if.scan_active), 32'd1);

        // Fill a full row 10..13, then swap
        for (int i = 0; i < 4; i++) step(1'b1, 24'(10 + i), 1'b0, 1'b0, 1'b0);
        chk("r040_ready_low", 32'(bus_if.in_ready), 32'd0);
        step(1'b0, 24'd0, 1'b1, 1'b0, 1'b0);
        chk("r040_row_valid", 32'(bus_if.row_valid), 32'd1);
        chk("r040_ready_back", 32'(bus_if.in_ready), 32'd1);

        // Scan with pix_req held: 0,1,2,3 then idle holding at 3
        for (int i = 0; i < 6; i++) step(1'b0, 24'd0, 1'b0, 1'b1, 1'b0);
        chk("r043_idle", 32'(bus_if.scan_active), 32'd0);
        chk("r043_hold", 32'(bus_if.mem_address_read), 32'd3);
        step(1'b0, 24'd0, 1'b1, 1'b1, 1'b0);
        chk("r043_restart", 32'(bus_if.mem_address_read), 32'd0);

        // Underrun after 2 accepts; third accept lands at address 2
        step(1'b1, 24'd20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'd21, 1'b0, 1'b0, 1'b0);
        step(1'b0, 24'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 24'd22, 1'b0, 1'b0, 1'b0);

        // Last accept coincides with line_start: write and swap together
        step(1'b1, 24'd23, 1'b1, 1'b0, 1'b0);
        step(1'b1, 24'd30, 1'b0, 1'b0, 1'b0);

        // Reset mid-row discards progress
        step(1'b1, 24'd31, 1'b0, 1'b0, 1'b0);
        step(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 24'd40, 1'b0, 1'b0, 1'b0);
        chk("r045_row_valid", 32'(bus_if.row_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 24'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
